// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_NONE = 3'd0,
        MD_MUL  = 3'd1,
        MD_MULU = 3'd2,
        MD_DIV  = 3'd3,
        MD_DIVU = 3'd4,
        MD_MTHI = 3'd5,
        MD_MTLO = 3'd6
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    function automatic logic op_is_signed(input muldiv_op_t o);
        return (o == MD_MUL) || (o == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply (mode 0) or restoring divide (mode 1).
module muldiv_step #(
    parameter int WIDTH = 64
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc_i} + (q_i[0] ? {1'b0, opnd_i} : '0);
        shifted = {acc_i, q_i[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_i};
        acc_o   = sum[WIDTH:1];
        q_o     = {sum[0], q_i[WIDTH-1:1]};
        if (div_i) begin
            // Partial remainder is always below the divisor, so a set MSB means borrow.
            if (diff[WIDTH]) begin
                acc_o = shifted[WIDTH-1:0];
                q_o   = {q_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = diff[WIDTH-1:0];
                q_o   = {q_i[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle mul/div sequencer owning HI/LO; stalls EX while HI/LO would be stale.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             abort,
    input  logic             hilo_read,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    muldiv_state_t    state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q, q_q, opnd_q, hi_q, lo_q;
    logic             div_q, sa_q, sb_q, done_q;

    logic [WIDTH-1:0]   acc_d, q_d, a_mag, b_mag, quot_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic               a_neg, b_neg, is_mul_op, is_div_op;

    always_comb begin
        a_neg     = op_is_signed(op) & a[WIDTH-1];
        b_neg     = op_is_signed(op) & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        is_mul_op = (op == MD_MUL) || (op == MD_MULU);
        is_div_op = (op == MD_DIV) || (op == MD_DIVU);
        prod_fix  = (sa_q ^ sb_q) ? -{acc_q, q_q} : {acc_q, q_q};
        quot_fix  = (sa_q ^ sb_q) ? -q_q : q_q;
        rem_fix   = sa_q ? -acc_q : acc_q;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_i  (div_q),
        .acc_i  (acc_q),
        .q_i    (q_q),
        .opnd_i (opnd_q),
        .acc_o  (acc_d),
        .q_o    (q_d)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (start && !flush) begin
                        if (is_mul_op) begin
                            div_q   <= 1'b0;
                            acc_q   <= '0;
                            q_q     <= b_mag;
                            opnd_q  <= a_mag;
                            sa_q    <= a_neg;
                            sb_q    <= b_neg;
                            cnt_q   <= CW'(WIDTH - 1);
                            state_q <= BUSY;
                        end else if (is_div_op) begin
                            div_q  <= 1'b1;
                            opnd_q <= b_mag;
                            cnt_q  <= CW'(WIDTH - 1);
                            // Divide by zero: preload the final raw result, FIX passes it through.
                            if (b == '0) begin
                                acc_q   <= a;
                                q_q     <= '1;
                                sa_q    <= 1'b0;
                                sb_q    <= 1'b0;
                                state_q <= FIX;
                            end else begin
                                acc_q   <= '0;
                                q_q     <= a_mag;
                                sa_q    <= a_neg;
                                sb_q    <= b_neg;
                                state_q <= BUSY;
                            end
                        end else if (op == MD_MTHI) begin
                            hi_q <= a;
                        end else if (op == MD_MTLO) begin
                            lo_q <= a;
                        end
                    end
                    BUSY: begin
                        acc_q <= acc_d;
                        q_q   <= q_d;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == '0) state_q <= FIX;
                    end
                    FIX: begin
                        if (div_q) begin
                            lo_q <= quot_fix;
                            hi_q <= rem_fix;
                        end else begin
                            {hi_q, lo_q} <= prod_fix;
                        end
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy  = (state_q != IDLE);
    assign stall = busy & (start | hilo_read);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
